// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions for the fetch stage: reset/exception vectors,
// fetch controller state encoding and small PC helper functions.
package cpu_defs_pkg;

    // Boot PC taken on reset (kseg1 boot ROM).
    localparam logic [31:0] PC_RESET         = 32'hBFC0_0000;

    // Exception vectors (BEV=1 general vector, BEV=0 general vector).
    localparam logic [31:0] EXC_VEC_BEV1     = 32'hBFC0_0380;
    localparam logic [31:0] EXC_VEC_BEV0     = 32'h8000_0180;

    // Fetch controller state: RUN has no pending redirect, WAIT_DS holds a
    // jump target until the delay slot has been accepted by the icache.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        WAIT_DS = 1'b1
    } fetch_state_e;

    // Word-aligned fetch check on the two low PC bits.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return (pc_lo != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction fetch request/address handshake between the fetch stage
// (master) and the instruction cache (slave).
interface pc_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok
    );
endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer holding a jump target while the delay slot fetch is
// still waiting for the icache. Clear and consume both empty the entry;
// a set is only taken while empty so a latched target is never overwritten.
module pc_redirect_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_target,
    input  logic              clear,
    input  logic              consume,
    output logic              valid,
    output logic [ADDR_W-1:0] target
);

    // Pending entry: reset/clear/consume empty it, set fills it when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (clear || consume) begin
            valid  <= 1'b0;
        end else if (set && !valid) begin
            valid  <= 1'b1;
            target <= set_target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC generator. Resolves exception, branch and jump redirects
// (honouring the MIPS delay slot), holds a jump target across icache stalls,
// drives the fetch request and produces PC / PC+4 for the IF/ID register.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = cpu_defs_pkg::PC_RESET,
    parameter int          ADDR_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_f,
    input  logic                   jump_d,
    input  logic [ADDR_W-1:0]      pc_jump_d,
    input  logic                   branch_e,
    input  logic [ADDR_W-1:0]      pc_branch_e,
    input  logic                   except_m,
    input  logic [ADDR_W-1:0]      pc_except_m,
    pc_fetch_ctrl_if.master        ibus,
    output logic [ADDR_W-1:0]      pc_f,
    output logic [ADDR_W-1:0]      pc_plus4_f,
    output logic                   adel_f,
    output logic                   redirect_pend
);
    import cpu_defs_pkg::*;

    localparam logic [0:0] ST_RUN     = RUN;
    localparam logic [0:0] ST_WAIT_DS = WAIT_DS;

    logic              accept;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic [0:0]        state;
    logic [ADDR_W-1:0] pc_next;
    logic              pend_set;
    logic              pend_clear;
    logic              pend_consume;

    // Fetch request, address error and icache handshake decode.
    always_comb begin
        adel_f        = pc_misaligned(pc_f[1:0]);
        ibus.inst_req = ~rst & ~stall_f & ~adel_f;
        ibus.inst_addr = pc_f;
        accept        = ibus.inst_req & ibus.inst_addr_ok;
        pc_plus4_f    = pc_f + ADDR_W'(4);
        state         = pend_valid ? ST_WAIT_DS : ST_RUN;
        redirect_pend = pend_valid;
    end

    // Next-PC selection: exception, then branch, then pending/new jump,
    // then sequential advance on an accepted fetch.
    always_comb begin
        pc_next      = pc_f;
        pend_set     = 1'b0;
        pend_clear   = 1'b0;
        pend_consume = 1'b0;
        if (except_m) begin
            pc_next    = pc_except_m;
            pend_clear = 1'b1;
        end else if (branch_e) begin
            // The delay slot is already in decode, so redirect immediately.
            pc_next    = pc_branch_e;
            pend_clear = 1'b1;
        end else begin
            case (state)
                ST_WAIT_DS: begin
                    if (accept) begin
                        pc_next      = pend_target;
                        pend_consume = 1'b1;
                    end
                end
                default: begin
                    if (jump_d) begin
                        // The word at pc_f is the delay slot: jump only once
                        // it has been handed to the icache, else park the target.
                        if (accept) begin
                            pc_next = pc_jump_d;
                        end else begin
                            pend_set = 1'b1;
                        end
                    end else if (accept) begin
                        pc_next = pc_plus4_f;
                    end
                end
            endcase
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f <= RESET_PC[ADDR_W-1:0];
        end else begin
            pc_f <= pc_next;
        end
    end

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk        (clk),
        .rst        (rst),
        .set        (pend_set),
        .set_target (pc_jump_d),
        .clear      (pend_clear),
        .consume    (pend_consume),
        .valid      (pend_valid),
        .target     (pend_target)
    );

    // A jump inside a delay slot is illegal; the latched target is kept.
    jump_in_delay_slot_a: assert property (
        @(posedge clk) disable iff (rst)
        !(jump_d && pend_valid && !except_m && !branch_e)
    );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed scenarios followed by randomized
// traffic, checked against a behavioural next-PC model.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        jump_d;
    logic [31:0] pc_jump_d;
    logic        branch_e;
    logic [31:0] pc_branch_e;
    logic        except_m;
    logic [31:0] pc_except_m;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        adel_f;
    logic        redirect_pend;

    int checks;
    int failures;

    // Reference model state: current PC and a queue of parked jump targets.
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    pc_fetch_ctrl_if #(.ADDR_W(32)) bus ();

    pc_fetch_ctrl #(
        .RESET_PC (32'hBFC0_0000),
        .ADDR_W   (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_f       (stall_f),
        .jump_d        (jump_d),
        .pc_jump_d     (pc_jump_d),
        .branch_e      (branch_e),
        .pc_branch_e   (pc_branch_e),
        .except_m      (except_m),
        .pc_except_m   (pc_except_m),
        .ibus          (bus.master),
        .pc_f          (pc_f),
        .pc_plus4_f    (pc_plus4_f),
        .adel_f        (adel_f),
        .redirect_pend (redirect_pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance model at the edge.
    task automatic cycle(input logic r, input logic st,
                         input logic j, input logic [31:0] pj,
                         input logic b, input logic [31:0] pb,
                         input logic e, input logic [31:0] pe,
                         input logic ok);
        logic exp_req;
        logic acc;
        rst = r; stall_f = st;
        jump_d = j; pc_jump_d = pj;
        branch_e = b; pc_branch_e = pb;
        except_m = e; pc_except_m = pe;
        bus.inst_addr_ok = ok;
        #3;
        exp_req = !r && !st && (m_pc[1:0] == 2'b00);
        chk("pc_f", pc_f, m_pc);
        chk("inst_addr", bus.inst_addr, m_pc);
        chk("pc_plus4_f", pc_plus4_f, m_pc + 32'd4);
        chk("inst_req", {31'd0, bus.inst_req}, {31'd0, exp_req});
        chk("adel_f", {31'd0, adel_f}, {31'd0, (m_pc[1:0] != 2'b00)});
        chk("redirect_pend", {31'd0, redirect_pend}, {31'd0, (m_pend.size() != 0)});
        acc = exp_req && ok;
        @(posedge clk);
        if (r) begin
            m_pc = 32'hBFC0_0000;
            m_pend.delete();
        end else if (e) begin
            m_pc = pe;
            m_pend.delete();
        end else if (b) begin
            m_pc = pb;
            m_pend.delete();
        end else if (m_pend.size() != 0) begin
            if (acc) m_pc = m_pend.pop_front();
        end else if (j) begin
            if (acc) m_pc = pj;
            else m_pend.push_back(pj);
        end else if (acc) begin
            m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    // Plain sequential cycle with the given icache readiness.
    task automatic seq(input logic ok);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, ok);
    endtask

    initial begin
        logic r, st, j, b, e, ok;
        logic [31:0] pj, pb, pe;
        checks = 0;
        failures = 0;
        rst = 1'b1; stall_f = 1'b0; jump_d = 1'b0; pc_jump_d = '0;
        branch_e = 1'b0; pc_branch_e = '0; except_m = 1'b0; pc_except_m = '0;
        bus.inst_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        m_pc = 32'hBFC0_0000;

        // Reset held: PC at boot vector, no request.
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        chk("reset_pc", pc_f, 32'hBFC0_0000);

        // Sequential fetch after reset release.
        seq(1'b1);
        chk("seq_1", pc_f, 32'hBFC0_0004);
        seq(1'b1);
        chk("seq_2", pc_f, 32'hBFC0_0008);
        seq(1'b1);
        seq(1'b1);
        chk("seq_4", pc_f, 32'hBFC0_0010);

        // Jump with the delay slot accepted in the same cycle.
        cycle(1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        chk("jump_accept", pc_f, 32'h8000_1000);
        chk("jump_accept_pend", {31'd0, redirect_pend}, 32'd0);

        // Move to BFC00020 via a branch, then a jump under a 3-cycle icache stall.
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0020, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h8000_2000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("ds_wait_pend", {31'd0, redirect_pend}, 32'd1);
        seq(1'b0);
        seq(1'b0);
        chk("ds_wait_hold", pc_f, 32'hBFC0_0020);
        seq(1'b1);
        chk("ds_release_pc", pc_f, 32'h8000_2000);
        chk("ds_release_pend", {31'd0, redirect_pend}, 32'd0);

        // Branch overrides a pending jump; exception overrides a jump.
        cycle(1'b0, 1'b0, 1'b1, 32'h8000_3000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_4000, 1'b0, 32'd0, 1'b0);
        chk("branch_over_pend", pc_f, 32'h8000_4000);
        chk("branch_clears_pend", {31'd0, redirect_pend}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h8000_5000, 1'b1, 32'h8000_6000, 1'b1, 32'hBFC0_0380, 1'b1);
        chk("except_priority", pc_f, 32'hBFC0_0380);

        // Fetch stall holds PC; exception during stall still redirects.
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        chk("stall_hold", pc_f, 32'hBFC0_0380);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8000_0180, 1'b1);
        chk("stall_except", pc_f, 32'h8000_0180);

        // Misaligned target: address error, no request, PC holds.
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8000_0002, 1'b1);
        seq(1'b1);
        seq(1'b1);
        chk("adel_hold", pc_f, 32'h8000_0002);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0380, 1'b1);
        chk("adel_recover", pc_f, 32'hBFC0_0380);

        // PC+4 wraps at the top of the address space.
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("wrap_plus4", pc_plus4_f, 32'h0000_0000);
        seq(1'b1);
        chk("wrap_pc", pc_f, 32'h0000_0000);

        // Reset while a jump target is parked.
        cycle(1'b0, 1'b0, 1'b1, 32'h8000_7000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("reset_mid_ds_pc", pc_f, 32'hBFC0_0000);
        chk("reset_mid_ds_pend", {31'd0, redirect_pend}, 32'd0);

        // Randomized traffic; jumps only issued outside a delay-slot wait.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            st = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 19) == 0);
            b  = ($urandom_range(0, 11) == 0);
            j  = (m_pend.size() == 0) && ($urandom_range(0, 5) == 0);
            ok = ($urandom_range(0, 3) != 0);
            pj = $urandom() & 32'hFFFF_FFFC;
            pb = $urandom() & 32'hFFFF_FFFC;
            pe = $urandom();
            if ($urandom_range(0, 3) != 0) pe = pe & 32'hFFFF_FFFC;
            cycle(r, st, j, pj, b, pb, e, pe, ok);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
